// File: rtl/lsu_bus_master_pkg.sv
// Shared types and constants for the load/store bus master.
// Holds RV32 funct3 encodings, the FSM state type and the access-size mask helper.
package lsu_bus_master_pkg;

    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

    localparam logic [2:0] STORE_BYTE = 3'b000;
    localparam logic [2:0] STORE_HALF = 3'b001;
    localparam logic [2:0] STORE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } lsu_state_t;

    // Unshifted byte mask; loads and stores share the size encoding in funct3[1:0].
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        logic [7:0] m;
        case (funct3 & 3'b011)
            STORE_BYTE: m = 8'h01;
            STORE_HALF: m = 8'h03;
            default:    m = 8'h0F;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational lane steering: byte enables, write-data shift and load merge/extract.
// Misaligned accesses span two words; the upper 4 mask bits describe the second beat.
module lsu_bus_master_lane_align
    import lsu_bus_master_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata0_i,
    input  logic [31:0] rdata1_i,
    output logic        split_o,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  mask;
    logic [63:0] wshift;
    logic [63:0] merged;
    logic [31:0] d;

    assign mask     = size_mask(funct3_i) << off_i;
    assign split_o  = |mask[7:4];
    assign be0_o    = mask[3:0];
    assign be1_o    = mask[7:4];

    assign wshift   = {32'b0, wdata_i} << {off_i, 3'b000};
    assign wdata0_o = wshift[31:0];
    assign wdata1_o = wshift[63:32];

    assign merged   = {rdata1_i, rdata0_i} >> {off_i, 3'b000};
    assign d        = merged[31:0];

    always_comb begin
        load_data_o = d;
        case (funct3_i)
            LOAD_B:  load_data_o = {{24{d[7]}}, d[7:0]};
            LOAD_BU: load_data_o = {24'b0, d[7:0]};
            LOAD_H:  load_data_o = {{16{d[15]}}, d[15:0]};
            LOAD_HU: load_data_o = {16'b0, d[15:0]};
            LOAD_W:  load_data_o = d;
            default: load_data_o = d;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: turns one scalar request into one or two word beats and returns
// a single response carrying the extended load data or an error flag.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    lsu_state_t        state_q, state_d;
    logic              we_q, err_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata0_q, rdata1_q;

    logic              accept, req_illegal, req_misaligned, req_err;
    logic              split;
    logic [3:0]        be0, be1;
    logic [31:0]       wdata0, wdata1, load_data;
    logic [ADDR_W-1:0] word0_addr, word1_addr;

    // Ready is forced low during reset even though the state register already reads IDLE.
    assign req_ready_o = (state_q == IDLE) && reset_ni;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        req_illegal    = req_we_i ? (req_funct3_i > STORE_WORD)
                                  : ((req_funct3_i[1:0] == 2'b11) || (req_funct3_i == 3'b110));
        req_misaligned = 1'b0;
        case (req_funct3_i[1:0])
            2'b01:   req_misaligned = req_addr_i[0];
            2'b10:   req_misaligned = (req_addr_i[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        req_err = req_illegal || (!ALLOW_MISALIGNED && req_misaligned);
    end

    assign word0_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign word1_addr = word0_addr + ADDR_W'(4);

    lsu_bus_master_lane_align u_lane_align (
        .funct3_i    (funct3_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata0_i    (rdata0_q),
        .rdata1_i    (rdata1_q),
        .split_o     (split),
        .be0_o       (be0),
        .be1_o       (be1),
        .wdata0_o    (wdata0),
        .wdata1_o    (wdata1),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : REQ0;
            REQ0:    if (bus_gnt_i) state_d = WAIT0;
            WAIT0:   if (bus_rvalid_i) state_d = split ? REQ1 : RESP;
            REQ1:    if (bus_gnt_i) state_d = WAIT1;
            WAIT1:   if (bus_rvalid_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = 4'b0;
        bus_wdata_o = 32'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = 32'b0;
        case (state_q)
            REQ0: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = word0_addr;
                bus_be_o    = be0;
                bus_wdata_o = wdata0;
            end
            REQ1: begin
                bus_req_o   = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = word1_addr;
                bus_be_o    = be1;
                bus_wdata_o = wdata1;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_rdata_o = (!we_q && !err_q) ? load_data : 32'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            rdata0_q <= 32'b0;
            rdata1_q <= 32'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we_i;
                err_q    <= req_err;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                // Zeroed so a single-beat load merges against an empty upper word.
                rdata0_q <= 32'b0;
                rdata1_q <= 32'b0;
            end
            if (state_q == WAIT0 && bus_rvalid_i) rdata0_q <= bus_rdata_i;
            if (state_q == WAIT1 && bus_rvalid_i) rdata1_q <= bus_rdata_i;
        end
    end

endmodule
